// File: rtl/fp_round_pack.sv
// fp_round_pack: two-stage round-and-pack stage with IEEE-style flags and valid/ready handshake

// grs_round: increment decision and inexact term from guard/round/sticky bits
module grs_round (
    input  logic       lsb,
    input  logic       g,
    input  logic       r,
    input  logic       s,
    input  logic       sign,
    input  logic [2:0] mode,
    output logic       inc,
    output logic       inexact
);
    localparam logic [2:0] RNE = 3'd0, RPI = 3'd2, RNI = 3'd3, RNA = 3'd4;
    // Directed modes round away from zero only on the matching sign; RTZ and unknown modes truncate
    always_comb begin
        inexact = g | r | s;
        inc = mode == RNE ? g & (r | s | lsb) :
              mode == RPI ? !sign & inexact :
              mode == RNI ? sign & inexact :
              mode == RNA ? g : 1'b0;
    end
endmodule

module fp_round_pack #(
    parameter int INPUT_WIDTH  = 28,
    parameter int OUTPUT_WIDTH = 24,
    parameter int EXP_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_WIDTH-1:0]    in_exp,
    input  logic [INPUT_WIDTH-1:0]  in_mant,
    input  logic [2:0]              in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic [EXP_WIDTH-1:0]    out_exp,
    output logic [OUTPUT_WIDTH-1:0] out_mant,
    output logic                    out_inexact,
    output logic                    out_overflow
);
    localparam int D = INPUT_WIDTH - OUTPUT_WIDTH;
    localparam logic [2:0] RNE = 3'd0, RPI = 3'd2, RNI = 3'd3, RNA = 3'd4;

    logic                    s1_valid, s1_sign, s1_inc, s1_inexact, s1_zero;
    logic [EXP_WIDTH-1:0]    s1_exp;
    logic [OUTPUT_WIDTH-1:0] s1_trunc;
    logic [2:0]              s1_mode;
    logic                    s2_load, s1_load, inc, inexact;
    logic [D+1:0]            ext;
    logic [OUTPUT_WIDTH:0]   sum;
    logic [EXP_WIDTH:0]      exp_res;
    logic [OUTPUT_WIDTH-1:0] mant_res, n_mant;
    logic [EXP_WIDTH-1:0]    n_exp;
    logic                    ovf, to_inf, n_inexact, n_overflow;

    assign s2_load  = !out_valid | out_ready;
    assign s1_load  = !s1_valid | s2_load;
    assign in_ready = s1_load;

    // Two zero bits appended so guard/round/sticky exist for any discard width >= 1
    assign ext = {in_mant[D-1:0], 2'b00};

    grs_round u_grs (
        .lsb    (in_mant[D]),
        .g      (ext[D+1]),
        .r      (ext[D]),
        .s      (|ext[D-1:0]),
        .sign   (in_sign),
        .mode   (in_mode),
        .inc    (inc),
        .inexact(inexact)
    );

    // S1: capture input fields together with the rounding decision
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_trunc   <= '0;
            s1_mode    <= '0;
            s1_inc     <= 1'b0;
            s1_inexact <= 1'b0;
            s1_zero    <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= in_sign;
                s1_exp     <= in_exp;
                s1_trunc   <= in_mant[INPUT_WIDTH-1 -: OUTPUT_WIDTH];
                s1_mode    <= in_mode;
                s1_inc     <= inc;
                s1_inexact <= inexact;
                s1_zero    <= in_mant == '0;
            end
        end
    end

    // Increment, renormalize on carry-out, and saturate to Inf or max finite by mode
    always_comb begin
        sum      = {1'b0, s1_trunc} + (OUTPUT_WIDTH+1)'(s1_inc);
        exp_res  = {1'b0, s1_exp} + (EXP_WIDTH+1)'(sum[OUTPUT_WIDTH]);
        mant_res = sum[OUTPUT_WIDTH] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}} : sum[OUTPUT_WIDTH-1:0];
        ovf      = exp_res >= {1'b0, {EXP_WIDTH{1'b1}}};
        to_inf   = s1_mode == RNE || s1_mode == RNA ? 1'b1 :
                   s1_mode == RPI ? !s1_sign :
                   s1_mode == RNI ? s1_sign : 1'b0;
        n_exp      = s1_zero ? '0 :
                     !ovf ? exp_res[EXP_WIDTH-1:0] :
                     to_inf ? {EXP_WIDTH{1'b1}} : {{(EXP_WIDTH-1){1'b1}}, 1'b0};
        n_mant     = s1_zero ? '0 :
                     !ovf ? mant_res :
                     to_inf ? '0 : {OUTPUT_WIDTH{1'b1}};
        n_inexact  = !s1_zero & (s1_inexact | ovf);
        n_overflow = !s1_zero & ovf;
    end

    // S2: packed result register driving the outputs; holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_sign     <= 1'b0;
            out_exp      <= '0;
            out_mant     <= '0;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign     <= s1_sign;
                out_exp      <= n_exp;
                out_mant     <= n_mant;
                out_inexact  <= n_inexact;
                out_overflow <= n_overflow;
            end
        end
    end
endmodule

// File: tb/tb_fp_round_pack.sv
// tb_fp_round_pack: randomized and directed checking of fp_round_pack against an arithmetic model
module tb_fp_round_pack;
    localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RPI = 3'd2, RNI = 3'd3, RNA = 3'd4;

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready, in_sign = 0, out_valid, out_ready = 1;
    logic [7:0]  in_exp = 0, out_exp;
    logic [27:0] in_mant = 0;
    logic [2:0]  in_mode = 0;
    logic        out_sign, out_inexact, out_overflow;
    logic [23:0] out_mant;

    int          n_vec = 0, n_err = 0;
    logic [34:0] q[$];
    logic [34:0] cur_exp;
    logic        rand_rdy = 0, saw_stall = 0;

    fp_round_pack dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
        .out_exp(out_exp), .out_mant(out_mant), .out_inexact(out_inexact),
        .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Expected {sign, exp, mant, inexact, overflow} from the rounding rules in plain arithmetic
    function automatic logic [34:0] model(logic s, logic [7:0] e, logic [27:0] m, logic [2:0] md);
        int unsigned frac = 32'(m[3:0]);
        longint      r = longint'(m[27:4]);
        int          ex = int'(e);
        bit          up, inf, inx;
        if (m == 0) return {s, 34'd0};
        case (md)
            RNE: up = frac > 8 || (frac == 8 && r % 2 == 1);
            RPI: up = frac != 0 && !s;
            RNI: up = frac != 0 && s;
            RNA: up = frac >= 8;
            default: up = 0;
        endcase
        r = r + (up ? 1 : 0);
        if (r == 64'd1 << 24) begin
            r = r / 2;
            ex = ex + 1;
        end
        inx = frac != 0;
        if (ex >= 255) begin
            inf = md == RNE || md == RNA || (md == RPI && !s) || (md == RNI && s);
            return inf ? {s, 8'hFF, 24'h0, 2'b11} : {s, 8'hFE, 24'hFFFFFF, 2'b11};
        end
        return {s, 8'(ex), 24'(r), inx, 1'b0};
    endfunction

    // Scoreboard: record accepted beats and check S2 contents every cycle it is valid
    always @(negedge clk) begin
        if (rst) q.delete();
        else begin
            if (in_valid && !in_ready) saw_stall = 1;
            if (out_valid) begin
                if (q.size() == 0) check("spurious_out", 1, 0);
                else begin
                    check("result", {out_sign, out_exp, out_mant, out_inexact, out_overflow}, q[0]);
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(cur_exp);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = $urandom_range(0, 1) == 1;
    end

    task automatic send(logic s, logic [7:0] e, logic [27:0] m, logic [2:0] md, logic lit, logic [34:0] want);
        int n = 0;
        in_valid = 1; in_sign = s; in_exp = e; in_mant = m; in_mode = md;
        cur_exp = lit ? want : model(s, e, m, md);
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) check("drain_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [27:0] m;
        logic [7:0]  e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out", {out_valid, out_sign, out_exp, out_mant, out_inexact, out_overflow}, 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Latency: accepted at one edge, visible two edges later
        send(0, 8'h40, 28'h8000018, RNE, 1, {1'b0, 8'h40, 24'h800002, 2'b10});
        @(negedge clk);
        check("latency_1", out_valid, 0);
        @(negedge clk);
        check("latency_2", out_valid, 1);
        drain();

        send(0, 8'h40, 28'h8000008, RNE, 1, {1'b0, 8'h40, 24'h800000, 2'b10});
        send(0, 8'h10, 28'hFFFFFF8, RNE, 1, {1'b0, 8'h11, 24'h800000, 2'b10});
        send(0, 8'hFE, 28'hFFFFFF8, RNE, 1, {1'b0, 8'hFF, 24'h000000, 2'b11});
        send(1, 8'hFF, 28'h8000000, RPI, 1, {1'b1, 8'hFE, 24'hFFFFFF, 2'b11});
        send(0, 8'h20, 28'h8000001, RTZ, 1, {1'b0, 8'h20, 24'h800000, 2'b10});
        send(0, 8'h20, 28'h8000001, RNI, 1, {1'b0, 8'h20, 24'h800000, 2'b10});
        send(0, 8'h20, 28'h8000001, RPI, 1, {1'b0, 8'h20, 24'h800001, 2'b10});
        send(1, 8'h20, 28'h8000001, RNI, 1, {1'b1, 8'h20, 24'h800001, 2'b10});
        send(1, 8'h55, 28'h0, RPI, 1, {1'b1, 34'd0});
        send(0, 8'hFF, 28'h0, RNE, 1, {1'b0, 34'd0});
        send(0, 8'h30, 28'h8000008, RNA, 1, {1'b0, 8'h30, 24'h800001, 2'b10});
        send(0, 8'hFE, 28'hFFFFFF8, RTZ, 1, {1'b0, 8'hFE, 24'hFFFFFF, 2'b10});
        send(1, 8'hFE, 28'hFFFFFF8, 3'd7, 1, {1'b1, 8'hFE, 24'hFFFFFF, 2'b10});
        send(1, 8'hFE, 28'hFFFFFFF, RNI, 1, {1'b1, 8'hFF, 24'h000000, 2'b11});
        drain();

        // Backpressure: five back-to-back beats with out_ready low for four cycles
        saw_stall = 0;
        fork
            for (int i = 0; i < 5; i++) send(i[0], 8'h60 + 8'(i), 28'h8000000 + 28'(i * 9), RNE, 0, 0);
            begin
                @(posedge clk);
                #1 out_ready = 0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();
        check("in_ready_stalled", saw_stall, 1);

        // Reset with both stages full
        out_ready = 0;
        send(0, 8'h70, 28'h9000000, RNE, 0, 0);
        send(0, 8'h71, 28'h9000000, RNE, 0, 0);
        @(negedge clk);
        check("full_before_reset", {out_valid, dut.s1_valid}, 2'b11);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        out_ready = 1;
        @(negedge clk);
        check("reset_midstream", {out_valid, out_sign, out_exp, out_mant, out_inexact, out_overflow}, 0);
        repeat (4) @(negedge clk);
        check("no_stale_beat", out_valid, 0);

        // Random stream with random backpressure and idle gaps
        rand_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            m = $urandom_range(0, 15) == 0 ? 28'h0 : 28'($urandom) | 28'h8000000;
            if ($urandom_range(0, 3) == 0) m[3:0] = 4'h8;
            e = $urandom_range(0, 3) == 0 ? 8'hFC + 8'($urandom_range(0, 3)) : 8'($urandom);
            send($urandom_range(0, 1) == 1, e, m, 3'($urandom_range(0, 7)), 0, 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 0;
        out_ready = 1;
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fp_round_pack.md
Name: fp_round_pack

Overview:
- Pipelined rounding-and-pack stage placed directly after normalization in the FP datapath.
- Accepts a normalized, unrounded mantissa with its exponent, sign and rounding mode.
- Instantiates grs_round for the increment decision, applies the increment, renormalizes on carry-out and handles exponent overflow per mode.
- Emits the packed result with IEEE-style inexact/overflow flags over a valid/ready handshake.

Parameters:
- INPUT_WIDTH, 28, width of the unrounded mantissa, hidden one at the MSB.
- OUTPUT_WIDTH, 24, width of the rounded mantissa, hidden one explicit at the MSB; must be < INPUT_WIDTH.
- EXP_WIDTH, 8, biased exponent width; all-ones encodes Inf.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept an input beat.
- in_sign  in  1  sign of the value.
- in_exp  in  EXP_WIDTH  biased exponent.
- in_mant  in  INPUT_WIDTH  normalized unrounded mantissa; MSB=1, or all-zero for zero.
- in_mode  in  3  rounding mode, `RNE/`RTZ/`RPI/`RNI/`RNA encodings from grs_round.vh.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sign  out  1  result sign, equal to in_sign.
- out_exp  out  EXP_WIDTH  result exponent.
- out_mant  out  OUTPUT_WIDTH  rounded mantissa.
- out_inexact  out  1  at least one truncated bit was nonzero, or overflow occurred.
- out_overflow  out  1  result overflowed to Inf or was clamped to max finite.

Behaviour:
- **Pipeline:** two register stages, S1 and S2, each with its own valid bit.
  - S1 captures the input fields and registers the grs_round increment and inexact terms, computed from in_mant, in_sign and in_mode.
  - S2 registers the packed result, and the out_* ports are driven from S2.
- **Latency and throughput:** 2 cycles from the in_valid&in_ready edge to out_valid when out_ready=1; throughput is 1 beat per cycle.
- **Handshake:**
  - S2 loads when !s2_valid | out_ready.
  - S1 loads when !s1_valid | s2 loads.
  - in_ready = !s1_valid | s2 loads; this is combinational, with no bubble at full throughput.
  - A stalled stage holds its data unchanged. out_* remain stable while out_valid & !out_ready.
  - No beat is dropped or duplicated, and order is preserved.
- **Arithmetic in S2:**
  - sum = {1'b0, mant_trunc} + increment, which is OUTPUT_WIDTH+1 bits, where mant_trunc = in_mant[INPUT_WIDTH-1 -: OUTPUT_WIDTH].
  - If sum[OUTPUT_WIDTH]=1: out_mant = {1'b1, zeros} and exp_res = in_exp+1.
  - Otherwise: out_mant = sum[OUTPUT_WIDTH-1:0] and exp_res = in_exp.
  - inexact = g|r|s of the discarded bits.
- **Zero input** (in_mant==0): out_exp=0, out_mant=0, inexact=0, overflow=0, sign passed through.
- **Overflow condition:** exp_res == all-ones, either from a carry or because in_exp was already all-ones with a nonzero mantissa. Then out_overflow=1 and out_inexact=1. The result depends on mode:
  - RNE and RNA give Inf.
  - RTZ gives max finite.
  - RPI gives Inf if sign=0, else max finite.
  - RNI gives Inf if sign=1, else max finite.
  - Undefined modes behave as RTZ.
  - Inf encoding: exp all-ones, mant 0.
  - Max finite encoding: exp all-ones minus 1, mant all-ones.
- **Reset:**
  - s1_valid=0 and s2_valid=0, so out_valid=0.
  - All out_* data and flags are 0.
  - in_ready is 1 in the cycle after reset deasserts.
  - A reset mid-stream discards in-flight beats without emitting them.
- **Subnormal inputs** are out of scope; the upstream stage guarantees a normalized MSB or zero.

Test Plan (INPUT_WIDTH=28, OUTPUT_WIDTH=24, EXP_WIDTH=8, out_ready=1 unless stated):
- **RNE tie-to-even:** in_mant=28'h8000018, exp=8'h40, sign=0, RNE -> 2 cycles later out_mant=24'h800002, out_exp=8'h40, inexact=1, overflow=0. Same stimulus with in_mant=28'h8000008 -> out_mant=24'h800000, inexact=1.
- **Carry renormalize:** in_mant=28'hFFFFFF8, exp=8'h10, RNE -> out_mant=24'h800000, out_exp=8'h11, inexact=1.
- **Exponent overflow by mode:** in_mant=28'hFFFFFF8, exp=8'hFE, RNE -> out_exp=8'hFF, out_mant=0, overflow=1. in_exp=8'hFF, in_mant=28'h8000000, sign=1, RPI -> out_exp=8'hFE, out_mant=24'hFFFFFF, overflow=1, inexact=1.
- **Mode sweep:** in_mant=28'h8000001, sign=0 -> RTZ and RNI give no increment, out_mant=24'h800000; RPI increments, out_mant=24'h800001; all three have inexact=1. in_mant=0 in any mode -> all-zero result, flags 0.
- **Backpressure:** stream 5 beats with in_valid held high, out_ready=0 for cycles 2-5 -> in_ready falls once S1 and S2 are full. All 5 results emerge in order with no loss, and out_* stay stable while stalled.
- **Reset mid-operation:** assert rst with S1 and S2 both valid -> next cycle out_valid=0, data outputs 0, and no stale beat is emitted afterwards.
